// File: rtl/song_recorder.sv
`default_nettype none
// ============================================================================
// Module      : song_recorder
// Description : Debounced piano-key note recorder that stores
//               {note, octave, duration} entries for later playback.
// Revision    : 1.0
// ============================================================================
module song_recorder #(
    parameter int TICK_DIV = 12_500_000,
    parameter int DEBOUNCE = 1_000_000,
    parameter int DEPTH    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  keys,
    input  logic [1:0]  octave,
    input  logic        write_on,
    input  logic [5:0]  rd_addr,
    output logic [11:0] rd_data,
    output logic [5:0]  song_len,
    output logic        recording,
    output logic        full
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DB_W   = $clog2(DEBOUNCE + 1);
    localparam int c_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE - 1);
    localparam logic [6:0]          c_LEN_LAST  = 7'(DEPTH - 1);
    localparam logic [5:0]          c_DUR_MAX   = 6'd63;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REC   = 2'd1;
    localparam logic [1:0] c_CLOSE = 2'd2;

    logic [3:0]          w_code;
    logic [3:0]          r_cand;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [3:0]          r_note;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_wr_q;
    logic                r_wr_qq;
    logic                w_wr_rise;
    logic                w_wr_fall;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_TICK_W-1:0] w_tick_nxt;
    logic                w_tick_wrap;
    logic [5:0]          r_dur;
    logic [5:0]          w_dur_nxt;
    logic [3:0]          r_cur_note;
    logic [1:0]          r_cur_oct;
    logic [6:0]          r_len;
    logic                r_full;
    logic                w_we;
    logic                w_load;
    logic                w_start;
    logic                w_leading_rest;
    logic [11:0]         w_wdata;
    logic [11:0]         r_rd_data;
    logic [11:0]         r_mem [DEPTH];

    // Lowest-indexed pressed key wins; no key pressed encodes a rest.
    always_comb begin
        w_code = 4'd0;
        for (int i = 6; i >= 0; i--) begin
            if (keys[i]) w_code = 4'(i + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cand   <= 4'd0;
            r_db_cnt <= '0;
            r_note   <= 4'd0;
        end else if (w_code != r_cand) begin
            r_cand   <= w_code;
            r_db_cnt <= c_DB_W'(1);
        end else if (r_db_cnt >= c_DB_LAST) begin
            r_note   <= r_cand;
        end else begin
            r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end
    end

    assign w_wr_rise      = r_wr_q & ~r_wr_qq;
    assign w_wr_fall      = ~r_wr_q & r_wr_qq;
    assign w_tick_wrap    = (r_tick == c_TICK_LAST);
    assign w_leading_rest = (r_cur_note == 4'd0) && (r_len == 7'd0);
    assign w_wdata        = {r_cur_note, r_cur_oct, r_dur};

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_dur_nxt   = r_dur;
        w_we        = 1'b0;
        w_load      = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_tick_nxt = '0;
                if (w_wr_rise) begin
                    w_state_nxt = c_REC;
                    w_start     = 1'b1;
                    w_load      = 1'b1;
                    w_dur_nxt   = 6'd0;
                end
            end
            c_REC: begin
                w_tick_nxt = w_tick_wrap ? '0 : r_tick + c_TICK_W'(1);
                if (w_wr_fall) begin
                    // Close wins over a simultaneous note change; the tick still counts.
                    w_state_nxt = c_CLOSE;
                    if (w_tick_wrap && (r_dur != c_DUR_MAX)) w_dur_nxt = r_dur + 6'd1;
                end else if (r_note != r_cur_note) begin
                    w_we      = (r_dur != 6'd0) && !w_leading_rest;
                    w_load    = 1'b1;
                    w_dur_nxt = 6'd0;
                end else if (w_tick_wrap) begin
                    if (r_dur == c_DUR_MAX) begin
                        w_we      = !w_leading_rest;
                        w_dur_nxt = 6'd0;
                    end else begin
                        w_dur_nxt = r_dur + 6'd1;
                    end
                end
                if (w_we && (r_len == c_LEN_LAST)) w_state_nxt = c_IDLE;
            end
            c_CLOSE: begin
                w_tick_nxt  = '0;
                w_we        = (r_dur != 6'd0) && (r_cur_note != 4'd0);
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_tick     <= '0;
            r_dur      <= 6'd0;
            r_wr_q     <= 1'b0;
            r_wr_qq    <= 1'b0;
            r_cur_note <= 4'd0;
            r_cur_oct  <= 2'd0;
            r_len      <= 7'd0;
            r_full     <= 1'b0;
            r_rd_data  <= 12'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_dur   <= w_dur_nxt;
            r_wr_q  <= write_on;
            r_wr_qq <= r_wr_q;
            if (w_load) begin
                r_cur_note <= r_note;
                r_cur_oct  <= octave;
            end
            if (w_start) begin
                r_len  <= 7'd0;
                r_full <= 1'b0;
            end else if (w_we) begin
                r_len <= r_len + 7'd1;
                if (r_len == c_LEN_LAST) r_full <= 1'b1;
            end
            r_rd_data <= ({1'b0, rd_addr} < r_len) ? r_mem[rd_addr[c_AW-1:0]] : 12'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_we) r_mem[r_len[c_AW-1:0]] <= w_wdata;
    end

    assign rd_data   = r_rd_data;
    assign song_len  = r_len[5:0];
    assign recording = (r_state == c_REC);
    assign full      = r_full;

endmodule
`default_nettype wire

// File: tb/tb_song_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_song_recorder
// Description : Self-checking bench for song_recorder (TICK_DIV=4,
//               DEBOUNCE=2, DEPTH=4) using a take table and a readback queue.
// Revision    : 1.0
// ============================================================================
module tb_song_recorder;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [6:0]  keys     = 7'd0;
    logic [1:0]  octave   = 2'd0;
    logic        write_on = 1'b0;
    logic [5:0]  rd_addr  = 6'd0;
    logic [11:0] rd_data;
    logic [5:0]  song_len;
    logic        recording;
    logic        full;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_q [$];

    typedef struct {
        logic [6:0]  keys;
        logic [1:0]  oct;
        int          hold;
        int          exp_len;
        logic [11:0] exp_entry;
    } take_t;

    take_t tbl [6];

    song_recorder #(
        .TICK_DIV (4),
        .DEBOUNCE (2),
        .DEPTH    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .keys      (keys),
        .octave    (octave),
        .write_on  (write_on),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .song_len  (song_len),
        .recording (recording),
        .full      (full)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] entry(input int note, input int oct, input int dur);
        logic [3:0] n;
        logic [1:0] o;
        logic [5:0] d;
        n = 4'(note);
        o = 2'(oct);
        d = 6'(dur);
        return {n, o, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        write_on = 1'b0;
        keys     = 7'd0;
        rd_addr  = 6'd0;
        tick(2);
        reset    = 1'b1;
    endtask

    // Pops every expected entry and compares it against the stored buffer.
    task automatic drain(input string tag);
        int          n;
        logic [11:0] e;
        n = exp_q.size();
        check({tag, "_len"}, 32'(song_len), 32'(n));
        for (int a = 0; a < n; a++) begin
            rd_addr = 6'(a);
            tick(1);
            e = exp_q.pop_front();
            check($sformatf("%s_entry%0d", tag, a), 32'(rd_data), 32'(e));
        end
        rd_addr = 6'(n);
        tick(1);
        check({tag, "_past_end"}, 32'(rd_data), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{7'b0000100, 2'd1, 12, 1, entry(3, 1, 3)};
        tbl[1] = '{7'b0000001, 2'd0,  4, 1, entry(1, 0, 1)};
        tbl[2] = '{7'b0100000, 2'd3,  7, 1, entry(6, 3, 1)};
        tbl[3] = '{7'b0010000, 2'd2,  3, 0, 12'd0};
        tbl[4] = '{7'b1010100, 2'd2, 20, 1, entry(3, 2, 5)};
        tbl[5] = '{7'b0000010, 2'd3, 16, 1, entry(2, 3, 4)};

        do_reset();
        check("reset_len", 32'(song_len), 32'd0);
        check("reset_full", 32'(full), 32'd0);
        check("reset_recording", 32'(recording), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);

        // Single-note takes; recording must drop two edges after write_on falls.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            if (tbl[i].exp_len > 0) exp_q.push_back(tbl[i].exp_entry);
            keys     = tbl[i].keys;
            octave   = tbl[i].oct;
            write_on = 1'b1;
            tick(tbl[i].hold);
            write_on = 1'b0;
            keys     = 7'd0;
            tick(1);
            check($sformatf("take%0d_rec_hold", i), 32'(recording), 32'd1);
            tick(1);
            check($sformatf("take%0d_rec_drop", i), 32'(recording), 32'd0);
            tick(2);
            drain($sformatf("take%0d", i));
        end

        // Leading silence is discarded.
        do_reset();
        exp_q.push_back(entry(1, 3, 2));
        exp_q.push_back(entry(2, 3, 2));
        octave   = 2'd3;
        write_on = 1'b1;
        tick(20);
        keys = 7'b0000001;
        tick(8);
        check("lead_rest_len", 32'(song_len), 32'd0);
        keys = 7'b0000010;
        tick(8);
        write_on = 1'b0;
        keys     = 7'd0;
        tick(5);
        drain("lead_rest");

        // Long note splits at the overflowing tick.
        do_reset();
        exp_q.push_back(entry(7, 2, 63));
        exp_q.push_back(entry(7, 2, 11));
        octave   = 2'd2;
        keys     = 7'b1000000;
        write_on = 1'b1;
        tick(257);
        check("long_before_split", 32'(song_len), 32'd0);
        tick(1);
        check("long_at_split", 32'(song_len), 32'd1);
        tick(42);
        write_on = 1'b0;
        keys     = 7'd0;
        tick(4);
        drain("long");

        // Fifth note does not fit.
        do_reset();
        for (int n = 1; n <= 4; n++) exp_q.push_back(entry(n, 1, 2));
        octave   = 2'd1;
        write_on = 1'b1;
        for (int k = 0; k < 5; k++) begin
            keys = 7'(1 << k);
            tick(8);
        end
        // Back up to edge 32 timing: loop ended at edge 40, so checks below use a fresh count.
        write_on = 1'b0;
        keys     = 7'd0;
        tick(5);
        check("full_flag", 32'(full), 32'd1);
        check("full_recording", 32'(recording), 32'd0);
        drain("full");

        // Exact cycle at which the buffer fills.
        do_reset();
        octave   = 2'd1;
        write_on = 1'b1;
        keys     = 7'b0000001;
        tick(8);
        keys = 7'b0000010;
        tick(8);
        keys = 7'b0000100;
        tick(8);
        keys = 7'b0001000;
        tick(8);
        keys = 7'b0010000;
        tick(2);
        check("fill_pre_full", 32'(full), 32'd0);
        check("fill_pre_len", 32'(song_len), 32'd3);
        check("fill_pre_rec", 32'(recording), 32'd1);
        tick(1);
        check("fill_full", 32'(full), 32'd1);
        check("fill_len", 32'(song_len), 32'd4);
        check("fill_rec", 32'(recording), 32'd0);
        tick(5);
        write_on = 1'b0;
        keys     = 7'd0;
        tick(5);

        // A new take clears full, then a reset mid-take abandons it.
        octave   = 2'd0;
        write_on = 1'b1;
        keys     = 7'b0000001;
        tick(1);
        check("newtake_full_held", 32'(full), 32'd1);
        tick(1);
        check("newtake_full_clr", 32'(full), 32'd0);
        check("newtake_len_clr", 32'(song_len), 32'd0);
        check("newtake_rec", 32'(recording), 32'd1);
        tick(6);
        keys = 7'b0000010;
        tick(4);
        check("midrec_len", 32'(song_len), 32'd1);
        rd_addr  = 6'd0;
        reset    = 1'b0;
        write_on = 1'b0;
        keys     = 7'd0;
        tick(1);
        check("abort_len", 32'(song_len), 32'd0);
        check("abort_rec", 32'(recording), 32'd0);
        check("abort_full", 32'(full), 32'd0);
        reset = 1'b1;
        tick(1);
        check("abort_rd0", 32'(rd_data), 32'd0);
        tick(6);
        check("abort_no_write", 32'(song_len), 32'd0);

        // One-cycle glitch is filtered and does not split the note.
        do_reset();
        exp_q.push_back(entry(2, 0, 4));
        octave   = 2'd0;
        write_on = 1'b1;
        keys     = 7'b0000010;
        tick(7);
        keys = 7'b0001000;
        tick(1);
        keys = 7'b0000010;
        tick(8);
        write_on = 1'b0;
        keys     = 7'd0;
        tick(5);
        drain("glitch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
